mcpu_scoreboard: RTL and testbench
==================================

Name: mcpu_scoreboard

Overview:
- Produces the `reg_scoreboard[31:0]` and `pred_scoreboard[2:0]` busy vectors that the decode stage uses to stall on hazards.
- Sets a pending mark when decode issues an instruction that writes a GPR or predicate.
- Clears the mark when a writeback port retires that write.
- Keeps a small outstanding-write counter per destination, so back-to-back writers to the same register are tracked correctly.

Parameters:
- CNT_W, 2, width of each per-destination outstanding-write counter; max count = 2^CNT_W-1.
- NUM_PREDS, 3, number of writable predicate registers (p0..p2).

Ports:
- clkrst_core_clk  input  1  core clock
- clkrst_core_rst_n  input  1  reset, synchronous, active-low
- issue_valid  input  1  an instruction leaves decode this cycle; already qualified by ~stall
- issue_rd_num  input  5  destination number of the issued instruction
- issue_rd_we  input  1  issued instruction writes GPR issue_rd_num
- issue_pred_we  input  1  issued instruction writes predicate issue_rd_num[1:0]
- wb0_valid  input  1  ALU writeback port retires a write
- wb0_rd_num  input  5  ALU writeback destination
- wb0_rd_we  input  1  ALU retires a GPR write
- wb0_pred_we  input  1  ALU retires a predicate write
- wb1_valid  input  1  LSU writeback port retires a write
- wb1_rd_num  input  5  LSU writeback destination
- wb1_rd_we  input  1  LSU retires a GPR write
- wb1_pred_we  input  1  LSU retires a predicate write
- flush  input  1  discard all pending state; asserted only when the pipeline is drained or squashed
- reg_scoreboard  output  32  bit i = GPR i has at least one outstanding write
- pred_scoreboard  output  NUM_PREDS  bit i = predicate i has at least one outstanding write
- sb_error  output  1  sticky: counter overflow or underflow occurred

Behaviour:
- State:
  - 32 GPR counters and NUM_PREDS predicate counters, each CNT_W bits wide.
  - sb_error flop.
- Outputs are combinational from the counters: bit = (counter != 0). There are no other output flops.
- Reset: while clkrst_core_rst_n=0 at a clock edge, all counters go to 0 and sb_error goes to 0. Both scoreboard outputs therefore read all-zero the cycle after reset. Reset overrides all other inputs, including mid-operation.
- Issue increment (inc=1 for the target counter):
  - GPR: when issue_valid & issue_rd_we, target is counter issue_rd_num.
  - Predicate: when issue_valid & issue_pred_we & issue_rd_num < NUM_PREDS, target is predicate counter issue_rd_num[1:0].
  - A predicate write with issue_rd_num >= NUM_PREDS is ignored and is not an error.
  - rd_we and pred_we both set: both counters are incremented.
- Writeback decrement: the same rules apply per port, gated by wbN_valid. Each port contributes dec=1 to its target counter.
- Per counter, next = cur + inc − dec0 − dec1, evaluated in CNT_W+2 signed arithmetic:
  - Result > max: hold cur, set sb_error.
  - Result < 0: clamp to 0, set sb_error.
  - Otherwise: take the result.
- Simultaneous events:
  - Issue and one writeback to the same register in one cycle: net unchanged. The bit stays set if cur > 0, and stays clear if cur = 0 with no error.
  - wb0 and wb1 to the same register: decrement by 2.
- Latency: an event in cycle N is visible on the outputs in cycle N+1. There is no same-cycle bypass; decode stalls one extra cycle on a retiring register, which is intentional.
- Flush:
  - All counters go to 0 at the next edge, overriding issue and writeback that cycle.
  - sb_error is retained.
- sb_error clears only on reset.
- No handshake backpressure: the block always accepts all inputs.

Test Plan:
1. Reset, then issue r5 (issue_rd_we=1) in cycle 1 → reg_scoreboard = 32'h0000_0020 in cycle 2. wb0 r5 in cycle 3 → 32'h0 in cycle 4; sb_error=0.
2. Issue r7 three times on consecutive cycles, then one wb1 r7 → bit 7 stays set. Two more writebacks → clear on the cycle after the last one. A fourth issue while count=3 → count holds at 3, sb_error=1.
3. Same-cycle issue r9 and wb0 r9 with count=1 → count remains 1 and bit 9 stays set. With count=0 → bit 9 stays clear and sb_error=0.
4. Issue pred_we with rd_num=2 → pred_scoreboard=3'b100 next cycle. pred_we with rd_num=3 → no change. wb1 pred 2 → 3'b000.
5. Count of r1=2, then wb0 r1 and wb1 r1 in the same cycle → 0 next cycle, no error. A further wb0 r1 → stays 0, sb_error=1.
6. Several registers pending, then flush together with issue r3 → both scoreboards read 0 next cycle, sb_error unchanged. Then drop rst_n mid-stream with pending bits → all outputs 0 next cycle, sb_error=0.

Source files
------------

// File: rtl/mcpu_scoreboard.sv
// Register/predicate hazard scoreboard for the decode stage.
// Each destination keeps a small outstanding-write counter; a busy bit is
// simply "counter non-zero". Issue increments, each writeback port decrements.
module mcpu_scoreboard #(
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned NUM_PREDS = 3
) (
  input  logic                 clkrst_core_clk,
  input  logic                 clkrst_core_rst_n,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd_num,
  input  logic                 issue_rd_we,
  input  logic                 issue_pred_we,
  input  logic                 wb0_valid,
  input  logic [4:0]           wb0_rd_num,
  input  logic                 wb0_rd_we,
  input  logic                 wb0_pred_we,
  input  logic                 wb1_valid,
  input  logic [4:0]           wb1_rd_num,
  input  logic                 wb1_rd_we,
  input  logic                 wb1_pred_we,
  input  logic                 flush,
  output logic [31:0]          reg_scoreboard,
  output logic [NUM_PREDS-1:0] pred_scoreboard,
  output logic                 sb_error
);

  localparam int unsigned SW = CNT_W + 2;
  localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] gpr_cnt_q  [32];
  logic [CNT_W-1:0] gpr_cnt_d  [32];
  logic [CNT_W-1:0] pred_cnt_q [NUM_PREDS];
  logic [CNT_W-1:0] pred_cnt_d [NUM_PREDS];
  logic             sb_error_q;
  logic             sb_error_d;
  logic [CNT_W:0]   step;

  // Returns {error, next_count}: overflow holds the count, underflow clamps to 0.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cur,
                                               input logic inc,
                                               input logic dec0,
                                               input logic dec1);
    logic signed [SW-1:0] sum;
    sum = $signed({2'b00, cur}) + $signed(SW'(inc))
        - $signed(SW'(dec0)) - $signed(SW'(dec1));
    if (sum[SW-1]) begin
      cnt_step = {1'b1, {CNT_W{1'b0}}};
    end else if (sum > CNT_MAX) begin
      cnt_step = {1'b1, cur};
    end else begin
      cnt_step = {1'b0, sum[CNT_W-1:0]};
    end
  endfunction

  // Next-state for every counter and the sticky error flag.
  always_comb begin
    gpr_cnt_d  = gpr_cnt_q;
    pred_cnt_d = pred_cnt_q;
    sb_error_d = sb_error_q;
    step       = '0;
    if (flush) begin
      for (int unsigned i = 0; i < 32; i++) begin
        gpr_cnt_d[i] = '0;
      end
      for (int unsigned i = 0; i < NUM_PREDS; i++) begin
        pred_cnt_d[i] = '0;
      end
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        step = cnt_step(gpr_cnt_q[i],
                        issue_valid & issue_rd_we & (issue_rd_num == 5'(i)),
                        wb0_valid   & wb0_rd_we   & (wb0_rd_num   == 5'(i)),
                        wb1_valid   & wb1_rd_we   & (wb1_rd_num   == 5'(i)));
        gpr_cnt_d[i] = step[CNT_W-1:0];
        sb_error_d   = sb_error_d | step[CNT_W];
      end
      // Matching the full 5-bit number against i < NUM_PREDS drops
      // out-of-range predicate writes without a separate range check.
      for (int unsigned i = 0; i < NUM_PREDS; i++) begin
        step = cnt_step(pred_cnt_q[i],
                        issue_valid & issue_pred_we & (issue_rd_num == 5'(i)),
                        wb0_valid   & wb0_pred_we   & (wb0_rd_num   == 5'(i)),
                        wb1_valid   & wb1_pred_we   & (wb1_rd_num   == 5'(i)));
        pred_cnt_d[i] = step[CNT_W-1:0];
        sb_error_d    = sb_error_d | step[CNT_W];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        gpr_cnt_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_PREDS; i++) begin
        pred_cnt_q[i] <= '0;
      end
      sb_error_q <= 1'b0;
    end else begin
      gpr_cnt_q  <= gpr_cnt_d;
      pred_cnt_q <= pred_cnt_d;
      sb_error_q <= sb_error_d;
    end
  end

  // Busy bits decoded straight from the counters.
  always_comb begin
    reg_scoreboard  = '0;
    pred_scoreboard = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      reg_scoreboard[i] = |gpr_cnt_q[i];
    end
    for (int unsigned i = 0; i < NUM_PREDS; i++) begin
      pred_scoreboard[i] = |pred_cnt_q[i];
    end
  end

  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_mcpu_scoreboard.sv
// Scoreboard-style bench for mcpu_scoreboard: the driver updates an
// integer-count reference model and queues the expected outputs; a monitor
// pops and compares one entry per cycle.
module tb_mcpu_scoreboard;

  localparam int MAXC = 3;
  localparam int NP   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_rd_we, issue_pred_we;
  logic [4:0]  issue_rd_num;
  logic        wb0_valid, wb0_rd_we, wb0_pred_we;
  logic [4:0]  wb0_rd_num;
  logic        wb1_valid, wb1_rd_we, wb1_pred_we;
  logic [4:0]  wb1_rd_num;
  logic        flush;
  logic [31:0] reg_scoreboard;
  logic [2:0]  pred_scoreboard;
  logic        sb_error;

  always #5 clk = ~clk;

  mcpu_scoreboard #(.CNT_W(2), .NUM_PREDS(3)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .issue_valid       (issue_valid),
    .issue_rd_num      (issue_rd_num),
    .issue_rd_we       (issue_rd_we),
    .issue_pred_we     (issue_pred_we),
    .wb0_valid         (wb0_valid),
    .wb0_rd_num        (wb0_rd_num),
    .wb0_rd_we         (wb0_rd_we),
    .wb0_pred_we       (wb0_pred_we),
    .wb1_valid         (wb1_valid),
    .wb1_rd_num        (wb1_rd_num),
    .wb1_rd_we         (wb1_rd_we),
    .wb1_pred_we       (wb1_pred_we),
    .flush             (flush),
    .reg_scoreboard    (reg_scoreboard),
    .pred_scoreboard   (pred_scoreboard),
    .sb_error          (sb_error)
  );

  typedef struct {
    logic       rst_n;
    logic       iv;  logic [4:0] ird;  logic iwe;  logic ipwe;
    logic       w0v; logic [4:0] w0rd; logic w0we; logic w0pwe;
    logic       w1v; logic [4:0] w1rd; logic w1we; logic w1pwe;
    logic       fl;
  } stim_t;

  typedef struct {
    logic [31:0] rsb;
    logic [2:0]  psb;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   gcnt [32];
  int   pcnt [NP];
  logic merr;
  int   total = 0;
  int   bad   = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t iss(input int r);
    stim_t s;
    s = idle(); s.iv = 1'b1; s.ird = 5'(r); s.iwe = 1'b1;
    return s;
  endfunction

  function automatic stim_t wb0(input int r);
    stim_t s;
    s = idle(); s.w0v = 1'b1; s.w0rd = 5'(r); s.w0we = 1'b1;
    return s;
  endfunction

  function automatic stim_t wb1(input int r);
    stim_t s;
    s = idle(); s.w1v = 1'b1; s.w1rd = 5'(r); s.w1we = 1'b1;
    return s;
  endfunction

  // Reference rule: outstanding count changes by the net delta; going above
  // MAXC keeps the old count, going below zero pins at zero; both are errors.
  function automatic void upd(inout int c, input int d);
    int n;
    n = c + d;
    if (n > MAXC) merr = 1'b1;
    else if (n < 0) begin merr = 1'b1; c = 0; end
    else c = n;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n;
    issue_valid = s.iv;  issue_rd_num = s.ird; issue_rd_we = s.iwe; issue_pred_we = s.ipwe;
    wb0_valid = s.w0v;   wb0_rd_num = s.w0rd;  wb0_rd_we = s.w0we;  wb0_pred_we = s.w0pwe;
    wb1_valid = s.w1v;   wb1_rd_num = s.w1rd;  wb1_rd_we = s.w1we;  wb1_pred_we = s.w1pwe;
    flush = s.fl;
    if (!s.rst_n) begin
      foreach (gcnt[r]) gcnt[r] = 0;
      foreach (pcnt[p]) pcnt[p] = 0;
      merr = 1'b0;
    end else if (s.fl) begin
      foreach (gcnt[r]) gcnt[r] = 0;
      foreach (pcnt[p]) pcnt[p] = 0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        int d;
        d = 0;
        if (s.iv  && s.iwe  && int'(s.ird)  == r) d++;
        if (s.w0v && s.w0we && int'(s.w0rd) == r) d--;
        if (s.w1v && s.w1we && int'(s.w1rd) == r) d--;
        upd(gcnt[r], d);
      end
      for (int p = 0; p < NP; p++) begin
        int d;
        d = 0;
        if (s.iv  && s.ipwe  && int'(s.ird)  < NP && int'(s.ird)  % 4 == p) d++;
        if (s.w0v && s.w0pwe && int'(s.w0rd) < NP && int'(s.w0rd) % 4 == p) d--;
        if (s.w1v && s.w1pwe && int'(s.w1rd) < NP && int'(s.w1rd) % 4 == p) d--;
        upd(pcnt[p], d);
      end
    end
    for (int r = 0; r < 32; r++) e.rsb[r] = (gcnt[r] != 0);
    for (int p = 0; p < NP; p++) e.psb[p] = (pcnt[p] != 0);
    e.err = merr;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs reflect the previous cycle's inputs, one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_scoreboard", reg_scoreboard, e.rsb);
        chk("pred_scoreboard", {29'b0, pred_scoreboard}, {29'b0, e.psb});
        chk("sb_error", {31'b0, sb_error}, {31'b0, e.err});
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_rd_num = '0; issue_rd_we = 1'b0; issue_pred_we = 1'b0;
    wb0_valid = 1'b0; wb0_rd_num = '0; wb0_rd_we = 1'b0; wb0_pred_we = 1'b0;
    wb1_valid = 1'b0; wb1_rd_num = '0; wb1_rd_we = 1'b0; wb1_pred_we = 1'b0;
    merr = 1'b0;

    s = idle(); s.rst_n = 1'b0;
    apply(s); apply(s);
    apply(idle());

    // Single issue / retire of r5.
    apply(iss(5)); apply(idle()); apply(wb0(5)); apply(idle());

    // Three writers to r7, drain, then overflow.
    repeat (3) apply(iss(7));
    repeat (3) apply(wb1(7));
    apply(idle());
    repeat (4) apply(iss(7));
    apply(idle());
    s = idle(); s.rst_n = 1'b0; apply(s);

    // Same-cycle issue and retire on r9, with count 1 and with count 0.
    apply(iss(9));
    s = iss(9); s.w0v = 1'b1; s.w0rd = 5'd9; s.w0we = 1'b1; apply(s);
    apply(wb0(9));
    s = iss(9); s.w0v = 1'b1; s.w0rd = 5'd9; s.w0we = 1'b1; apply(s);
    apply(idle());

    // Predicates: p2 set, out-of-range p3 ignored, p2 retired by wb1.
    s = idle(); s.iv = 1'b1; s.ird = 5'd2; s.ipwe = 1'b1; apply(s);
    s.ird = 5'd3; apply(s);
    s = idle(); s.w1v = 1'b1; s.w1rd = 5'd2; s.w1pwe = 1'b1; apply(s);
    s = idle(); s.iv = 1'b1; s.ird = 5'd0; s.iwe = 1'b1; s.ipwe = 1'b1; apply(s);
    s = idle(); s.w0v = 1'b1; s.w0rd = 5'd0; s.w0we = 1'b1; s.w0pwe = 1'b1; apply(s);

    // Dual retire of r1, then underflow.
    apply(iss(1)); apply(iss(1));
    s = wb0(1); s.w1v = 1'b1; s.w1rd = 5'd1; s.w1we = 1'b1; apply(s);
    apply(wb0(1));
    apply(idle());

    // Flush keeps the sticky error; reset clears everything.
    apply(iss(3)); apply(iss(10)); apply(iss(20));
    s = idle(); s.iv = 1'b1; s.ird = 5'd1; s.ipwe = 1'b1; apply(s);
    s = iss(3); s.fl = 1'b1; apply(s);
    apply(iss(4)); apply(iss(31));
    s = iss(6); s.rst_n = 1'b0; apply(s);
    apply(idle());

    // Random traffic on a narrow register window to force collisions.
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 299) != 0);
      s.fl    = ($urandom_range(0, 99) == 0);
      s.iv  = 1'($urandom_range(0, 1)); s.ird  = 5'($urandom_range(0, 7));
      s.iwe = 1'($urandom_range(0, 1)); s.ipwe = 1'($urandom_range(0, 1));
      s.w0v = 1'($urandom_range(0, 1)); s.w0rd = 5'($urandom_range(0, 7));
      s.w0we = 1'($urandom_range(0, 1)); s.w0pwe = 1'($urandom_range(0, 1));
      s.w1v = 1'($urandom_range(0, 1)); s.w1rd = 5'($urandom_range(0, 7));
      s.w1we = 1'($urandom_range(0, 1)); s.w1pwe = 1'($urandom_range(0, 1));
      apply(s);
    end
    apply(idle());

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
